// File: rtl/infoframe_packet_serializer_if.sv
// Packet-side bus of the data-island serializer: the packet handshake and payload
// coming in, and the per-pixel serialized word going out to the TERC4 stage.
`timescale 1ns/1ps
interface infoframe_packet_serializer_if;
    logic             pkt_valid;
    logic             pkt_ready;
    logic [23:0]      header;
    logic [3:0][55:0] sub;
    logic             advance;
    logic [8:0]       packet_data;
    logic             data_valid;
    logic             last;

    // Packet source / island scheduler side
    modport master (
        output pkt_valid, header, sub, advance,
        input  pkt_ready, packet_data, data_valid, last
    );

    // Serializer side
    modport slave (
        input  pkt_valid, header, sub, advance,
        output pkt_ready, packet_data, data_valid, last
    );
endinterface

// File: rtl/infoframe_packet_serializer.sv
// HDMI data-island packet serializer: shadows one packet (24-bit header plus four
// 56-bit subpackets), appends BCH parity on the fly and emits one 9-bit word per
// advancing pixel clock for 32 clocks.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no packet in flight, pkt_ready high
// ST_SEND | shadowed packet being emitted, r_cnt = index of next word
`timescale 1ns/1ps
module infoframe_packet_serializer (
    input  logic                           clk_pixel,
    input  logic                           reset_n,
    infoframe_packet_serializer_if.slave   bus
);
    typedef enum logic {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [4:0]       r_cnt;
    logic [23:0]      r_hdr;
    logic [3:0][55:0] r_sub;
    logic [7:0]       r_ecc_h;
    logic [3:0][7:0]  r_ecc_s;
    logic [8:0]       r_data;
    logic             r_valid;
    logic             r_last;

    logic             w_step;
    logic             w_cnt_end;
    logic             w_ready;
    logic             w_load;
    logic [23:0]      w_hdr_sh;
    logic [3:0][55:0] w_sub_sh;
    logic [8:0]       w_word;
    logic [7:0]       w_ecc_h_nxt;
    logic [3:0][7:0]  w_ecc_s_nxt;

    // One LFSR step of the BCH parity generator (polynomial folded into 8'h83)
    function automatic logic [7:0] bch_step(input logic [7:0] ecc, input logic b);
        logic fb;
        fb = ecc[0] ^ b;
        return (ecc >> 1) ^ (fb ? 8'h83 : 8'h00);
    endfunction

    assign w_cnt_end = (r_cnt == 5'd31);
    assign w_step    = (r_state == ST_SEND) && bus.advance;
    // The final word's cycle doubles as a load slot so packets can run back to back
    assign w_ready   = (r_state == ST_IDLE) || (w_step && w_cnt_end);
    assign w_load    = bus.pkt_valid && w_ready;

    assign bus.pkt_ready   = w_ready;
    assign bus.packet_data = r_data;
    assign bus.data_valid  = r_valid;
    assign bus.last        = r_last;

    // State register
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state: a load always wins, even on the last word of the current packet
    always_comb begin
        w_state_nxt = r_state;
        if (w_load)                   w_state_nxt = ST_SEND;
        else if (w_step && w_cnt_end) w_state_nxt = ST_IDLE;
    end

    // Word selection for the current count and the parity the step would leave behind;
    // parity stops moving once the data bits of a field are exhausted
    always_comb begin
        w_word      = '0;
        w_ecc_h_nxt = r_ecc_h;
        w_ecc_s_nxt = r_ecc_s;
        w_hdr_sh    = r_hdr >> r_cnt;
        w_sub_sh    = '0;
        if (r_cnt < 5'd24) begin
            w_word[0]   = w_hdr_sh[0];
            w_ecc_h_nxt = bch_step(r_ecc_h, w_hdr_sh[0]);
        end else begin
            w_word[0] = r_ecc_h[r_cnt[2:0]];
        end
        for (int k = 0; k < 4; k++) begin
            w_sub_sh[k] = r_sub[k] >> {r_cnt, 1'b0};
            if (r_cnt < 5'd28) begin
                w_word[1+k]    = w_sub_sh[k][0];
                w_word[5+k]    = w_sub_sh[k][1];
                w_ecc_s_nxt[k] = bch_step(bch_step(r_ecc_s[k], w_sub_sh[k][0]), w_sub_sh[k][1]);
            end else begin
                w_word[1+k] = r_ecc_s[k][{r_cnt[1:0], 1'b0}];
                w_word[5+k] = r_ecc_s[k][{r_cnt[1:0], 1'b1}];
            end
        end
    end

    // Shadow, counter, parity and output registers; a same-cycle load overrides the step
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_hdr   <= '0;
            r_sub   <= '0;
            r_ecc_h <= '0;
            r_ecc_s <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            if (w_step) begin
                r_data  <= w_word;
                r_valid <= 1'b1;
                r_last  <= w_cnt_end;
                r_cnt   <= r_cnt + 5'd1;
                r_ecc_h <= w_ecc_h_nxt;
                r_ecc_s <= w_ecc_s_nxt;
            end else begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
            if (w_load) begin
                r_hdr   <= bus.header;
                r_sub   <= bus.sub;
                r_ecc_h <= '0;
                r_ecc_s <= '0;
                r_cnt   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_infoframe_packet_serializer.sv
// Directed bench for the data-island packet serializer.
`timescale 1ns/1ps
module tb_infoframe_packet_serializer;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fails  = 0;
    logic [8:0] exp_words [32];

    infoframe_packet_serializer_if bus();

    infoframe_packet_serializer dut (
        .clk_pixel (clk),
        .reset_n   (rst_n),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] bch(input logic [7:0] e, input logic b);
        logic [7:0] r;
        r = e >> 1;
        if (e[0] ^ b) r = r ^ 8'h83;
        return r;
    endfunction

    // Reference: parity over the whole field, then read the 32 words out of {parity, data}
    task automatic build_exp(input logic [23:0] h, input logic [3:0][55:0] s);
        logic [7:0]  eh;
        logic [7:0]  es;
        logic [31:0] hfull;
        logic [63:0] full [4];
        eh = '0;
        for (int i = 0; i < 24; i++) eh = bch(eh, h[i]);
        hfull = {eh, h};
        for (int k = 0; k < 4; k++) begin
            es = '0;
            for (int i = 0; i < 56; i++) es = bch(es, s[k][i]);
            full[k] = {es, s[k]};
        end
        for (int c = 0; c < 32; c++) begin
            exp_words[c][0] = hfull[c];
            for (int k = 0; k < 4; k++) begin
                exp_words[c][1+k] = full[k][2*c];
                exp_words[c][5+k] = full[k][2*c+1];
            end
        end
    endtask

    function automatic logic [55:0] rnd56();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[55:0];
    endfunction

    // Called just after a clock edge; leaves time just after the loading edge
    task automatic load(input logic [23:0] h, input logic [3:0][55:0] s, input bit keep);
        bus.header    = h;
        bus.sub       = s;
        bus.pkt_valid = 1'b1;
        #1;
        check("load_ready", {31'd0, bus.pkt_ready}, 32'd1);
        @(posedge clk); #1;
        if (!keep) bus.pkt_valid = 1'b0;
    endtask

    // Receive words until stop_at have arrived; optionally alternate advance and
    // optionally try an illegal load once inject_at words have gone out
    task automatic collect(input bit toggle, input int stop_at, input int inject_at);
        int         idx = 0;
        int         cyc = 0;
        bit         adv;
        bit         injected = 1'b0;
        bit         drop;
        logic [8:0] prev = '0;
        while (idx < stop_at && cyc < 200) begin
            adv = toggle ? (cyc % 2 == 0) : 1'b1;
            bus.advance = adv;
            drop = 1'b0;
            if (idx == inject_at && !injected) begin
                bus.pkt_valid = 1'b1;
                bus.header    = bus.header ^ 24'hFFFFFF;
                bus.sub[2]    = ~bus.sub[2];
                #1;
                check("busy_ready", {31'd0, bus.pkt_ready}, 32'd0);
                injected = 1'b1;
                drop     = 1'b1;
            end
            @(posedge clk); #1;
            if (drop) bus.pkt_valid = 1'b0;
            if (adv) begin
                check("valid", {31'd0, bus.data_valid}, 32'd1);
                check($sformatf("word%0d", idx), {23'd0, bus.packet_data}, {23'd0, exp_words[idx]});
                check($sformatf("last%0d", idx), {31'd0, bus.last}, (idx == 31) ? 32'd1 : 32'd0);
                prev = exp_words[idx];
                idx++;
            end else begin
                check("stall_valid", {31'd0, bus.data_valid}, 32'd0);
                check("stall_data", {23'd0, bus.packet_data}, {23'd0, prev});
                check("stall_last", {31'd0, bus.last}, 32'd0);
            end
            cyc++;
        end
        if (idx < stop_at) check("timeout_words", idx, stop_at);
    endtask

    initial begin
        logic [3:0][55:0] s_a;
        logic [3:0][55:0] s_b;
        logic [3:0][55:0] s_z;
        logic [23:0]      h_v;

        bus.pkt_valid = 1'b0;
        bus.header    = '0;
        bus.sub       = '0;
        bus.advance   = 1'b0;
        s_z           = '0;

        // Reset values
        #1;
        check("rst_ready", {31'd0, bus.pkt_ready}, 32'd1);
        check("rst_valid", {31'd0, bus.data_valid}, 32'd0);
        check("rst_data", {23'd0, bus.packet_data}, 32'd0);
        check("rst_last", {31'd0, bus.last}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // All-zero packet: every word zero, parity zero
        for (int c = 0; c < 32; c++) exp_words[c] = 9'h000;
        bus.advance = 1'b1;
        load(24'h0, s_z, 1'b0);
        collect(1'b0, 32, -1);
        check("idle_ready", {31'd0, bus.pkt_ready}, 32'd1);
        @(posedge clk); #1;
        check("idle_valid", {31'd0, bus.data_valid}, 32'd0);

        // Hand-worked packet: only header bit 23 and sub0 bit 55 set, so both
        // parities see a single 1 as their final data bit and end at 8'h83
        for (int c = 0; c < 32; c++) exp_words[c] = 9'h000;
        exp_words[23] = 9'h001;
        exp_words[24] = 9'h001;
        exp_words[25] = 9'h001;
        exp_words[27] = 9'h020;
        exp_words[28] = 9'h022;
        exp_words[31] = 9'h021;
        s_a    = '0;
        s_a[0] = 56'h80000000000000;
        load(24'h800000, s_a, 1'b0);
        collect(1'b0, 32, -1);

        // Vendor-specific header with random payload
        h_v = 24'h050181;
        for (int k = 0; k < 4; k++) s_a[k] = rnd56();
        build_exp(h_v, s_a);
        load(h_v, s_a, 1'b0);
        collect(1'b0, 32, -1);

        // Same packet with advance alternating every clock
        load(h_v, s_a, 1'b0);
        collect(1'b1, 32, -1);
        bus.advance = 1'b1;

        // Back-to-back: second packet waits with pkt_valid high, loads on word 31
        for (int k = 0; k < 4; k++) s_b[k] = rnd56();
        build_exp(h_v, s_a);
        load(h_v, s_a, 1'b1);
        bus.header = 24'h0D0282;
        bus.sub    = s_b;
        collect(1'b0, 32, -1);
        bus.pkt_valid = 1'b0;
        build_exp(24'h0D0282, s_b);
        collect(1'b0, 32, -1);

        // Load attempt while busy must be ignored
        for (int k = 0; k < 4; k++) s_a[k] = rnd56();
        build_exp(24'h0A1B2C, s_a);
        @(posedge clk); #1;
        load(24'h0A1B2C, s_a, 1'b0);
        collect(1'b0, 32, 5);

        // Reset in the middle of a packet, then a clean packet
        for (int k = 0; k < 4; k++) s_b[k] = rnd56();
        build_exp(24'h123456, s_b);
        @(posedge clk); #1;
        load(24'h123456, s_b, 1'b0);
        collect(1'b0, 10, -1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'd0, bus.data_valid}, 32'd0);
        check("midrst_data", {23'd0, bus.packet_data}, 32'd0);
        check("midrst_last", {31'd0, bus.last}, 32'd0);
        check("midrst_ready", {31'd0, bus.pkt_ready}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("postrst_valid", {31'd0, bus.data_valid}, 32'd0);
        check("postrst_data", {23'd0, bus.packet_data}, 32'd0);
        for (int k = 0; k < 4; k++) s_a[k] = rnd56();
        build_exp(24'h8899AA, s_a);
        load(24'h8899AA, s_a, 1'b0);
        collect(1'b0, 32, -1);
        check("end_ready", {31'd0, bus.pkt_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
